// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_bus_arbiter: shares one single-port memory bus between instruction   |
// | fetch and data access; data has priority, fetch starvation is bounded.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_bus_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        imem_rd_i,
  input  logic [31:0] imem_addr_i,
  output logic        imem_gnt_o,
  output logic [31:0] inst_o,
  input  logic        dmem_rd_i,
  input  logic        dmem_wr_i,
  input  logic [3:0]  dmem_strobe_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  output logic        dmem_ready_o,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_rdata_valid_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_i_req = 3'd1;
  localparam logic [2:0] c_st_i_rsp = 3'd2;
  localparam logic [2:0] c_st_d_req = 3'd3;
  localparam logic [2:0] c_st_d_rsp = 3'd4;

  localparam int c_cnt_w = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_MAX);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_starve_cnt;
  logic               r_bus_req;
  logic               r_bus_we;
  logic [3:0]         r_bus_be;
  logic [31:0]        r_bus_addr;
  logic [31:0]        r_bus_wdata;
  logic [31:0]        r_fetch_addr;

  logic w_arb;
  logic w_data_cand;
  logic w_fetch_due;
  logic w_load_d;
  logic w_load_i;
  logic w_i_grant;

  always_comb begin
    w_state_nxt = r_state;
    w_arb       = 1'b0;
    case (r_state)
      c_st_idle:  w_arb = 1'b1;
      c_st_i_req: if (bus_gnt_i) w_state_nxt = c_st_i_rsp;
      c_st_i_rsp: if (bus_rvalid_i) w_arb = 1'b1;
      c_st_d_req: begin
        if (bus_gnt_i) begin
          if (r_bus_we) w_arb = 1'b1;
          else          w_state_nxt = c_st_d_rsp;
        end
      end
      c_st_d_rsp: if (bus_rvalid_i) w_arb = 1'b1;
      default:    w_state_nxt = c_st_idle;
    endcase

    // In the write-grant cycle the visible data request is the one just
    // acknowledged, so it must not be issued a second time.
    w_data_cand = (dmem_rd_i | dmem_wr_i) && (r_state != c_st_d_req);
    w_fetch_due = imem_rd_i && (STARVE_MAX != 0) && (r_starve_cnt == c_starve_max);
    w_load_d    = w_arb && w_data_cand && !w_fetch_due;
    w_load_i    = w_arb && !w_load_d && imem_rd_i;

    if (w_arb) begin
      if (w_load_d)      w_state_nxt = c_st_d_req;
      else if (w_load_i) w_state_nxt = c_st_i_req;
      else               w_state_nxt = c_st_idle;
    end
  end

  assign w_i_grant = (r_state == c_st_i_req) && bus_gnt_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= c_st_idle;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_be     <= 4'h0;
      r_bus_addr   <= 32'h0;
      r_bus_wdata  <= 32'h0;
      r_fetch_addr <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_d) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= dmem_wr_i;
        r_bus_be    <= dmem_strobe_i;
        r_bus_addr  <= dmem_addr_i;
        r_bus_wdata <= dmem_wdata_i;
      end else if (w_load_i) begin
        r_bus_req    <= 1'b1;
        r_bus_we     <= 1'b0;
        r_bus_be     <= 4'hF;
        r_bus_addr   <= imem_addr_i;
        r_bus_wdata  <= 32'h0;
        r_fetch_addr <= imem_addr_i;
      end else if (bus_gnt_i && ((r_state == c_st_i_req) || (r_state == c_st_d_req))) begin
        r_bus_req <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve_cnt <= '0;
    end else if (w_i_grant || (w_arb && !imem_rd_i)) begin
      r_starve_cnt <= '0;
    end else if (dmem_ready_o && imem_rd_i && (r_starve_cnt != c_starve_max)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign bus_req_o   = r_bus_req;
  assign bus_we_o    = r_bus_we;
  assign bus_be_o    = r_bus_be;
  assign bus_addr_o  = r_bus_addr;
  assign bus_wdata_o = r_bus_wdata;

  assign dmem_ready_o       = (r_state == c_st_d_req) && bus_gnt_i;
  assign dmem_rdata_valid_o = (r_state == c_st_d_rsp) && bus_rvalid_i;
  assign dmem_rdata_o       = dmem_rdata_valid_o ? bus_rdata_i : 32'h0;

  // A squashed fetch (PC moved or request withdrawn) completes on the bus silently.
  assign imem_gnt_o = (r_state == c_st_i_rsp) && bus_rvalid_i && imem_rd_i &&
                      (imem_addr_i == r_fetch_addr);
  assign inst_o     = imem_gnt_o ? bus_rdata_i : 32'h0;

endmodule
`default_nettype wire
